// File: rtl/des_iter_ctrl.sv
// des_iter_ctrl: iterative DES engine, one Feistel round per clock around a shared round block
module round (
    input  logic [47:0] subkey,
    input  logic [31:0] in_left,
    input  logic [31:0] in_right,
    output logic [31:0] out_left,
    output logic [31:0] out_right
);
    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    localparam int SBOX [512] = '{
        14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
         0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
         4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
        15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
        15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
         3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
         0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
        13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
        10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
        13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
         1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
         7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
        13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
        10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
         3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
         2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
        14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
         4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
        11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
        12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
        10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
         9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
         4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
         4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
        13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
         1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
         6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
        13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
         1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
         7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
         2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11};

    logic [47:0] w_e;
    logic [47:0] w_x;
    logic [31:0] w_s;
    logic [31:0] w_f;

    assign w_x       = w_e ^ subkey;
    assign out_left  = in_right;
    assign out_right = in_left ^ w_f;

    // expansion of the right half to 48 bits
    always_comb begin
        w_e = '0;
        for (int i = 0; i < 48; i++) w_e[47-i] = in_right[32-E_T[i]];
    end

    // S-box substitution: outer bits select the row, inner four the column
    always_comb begin
        int idx;
        idx = 0;
        w_s = '0;
        for (int s = 0; s < 8; s++) begin
            idx = s*64 + 32*int'(w_x[47-6*s]) + 16*int'(w_x[42-6*s]) + int'(w_x[46-6*s -: 4]);
            w_s[31-4*s -: 4] = 4'(SBOX[idx]);
        end
    end

    // P permutation of the substituted word
    always_comb begin
        w_f = '0;
        for (int i = 0; i < 32; i++) w_f[31-i] = w_s[32-P_T[i]];
    end
endmodule

module des_iter_ctrl #(
    parameter int NUM_ROUNDS = 16,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_block,
    input  logic [63:0]      in_key,
    input  logic             in_decrypt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_block,
    output logic             busy,
    output logic [CNT_W-1:0] round_idx
);
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7};
    localparam int FP_T [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25};
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam logic [1:0] SHIFT [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    function automatic logic [63:0] ip_f(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
        return y;
    endfunction

    function automatic logic [63:0] fp_f(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
        return y;
    endfunction

    function automatic logic [55:0] pc1_f(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
        return y;
    endfunction

    function automatic logic [47:0] pc2_f(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
        return y;
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic [1:0] n);
        return n == 2'd2 ? {x[25:0], x[27:26]} : n == 2'd1 ? {x[26:0], x[27]} : x;
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic [1:0] n);
        return n == 2'd2 ? {x[1:0], x[27:2]} : n == 2'd1 ? {x[0], x[27:1]} : x;
    endfunction

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_l;
    logic [31:0]      r_r;
    logic [27:0]      r_c;
    logic [27:0]      r_d;
    logic             r_mode;
    logic [CNT_W-1:0] r_cnt;
    logic [63:0]      r_out;
    logic             w_last;
    logic [CNT_W-1:0] w_rev;
    logic [1:0]       w_sl;
    logic [1:0]       w_sr;
    logic [27:0]      w_cl;
    logic [27:0]      w_dl;
    logic [27:0]      w_cn;
    logic [27:0]      w_dn;
    logic [47:0]      w_k;
    logic [31:0]      w_lo;
    logic [31:0]      w_ro;

    // Encryption rotates left before use; decryption uses the current C/D
    // and then rotates right by the mirrored schedule, walking K16 down to K1.
    assign w_last = r_cnt == CNT_W'(NUM_ROUNDS - 1);
    assign w_rev  = CNT_W'(NUM_ROUNDS - 1) - r_cnt;
    assign w_sl   = SHIFT[r_cnt];
    assign w_sr   = w_last ? 2'd0 : SHIFT[w_rev];
    assign w_cl   = rotl(r_c, w_sl);
    assign w_dl   = rotl(r_d, w_sl);
    assign w_k    = pc2_f(r_mode ? {r_c, r_d} : {w_cl, w_dl});
    assign w_cn   = r_mode ? rotr(r_c, w_sr) : w_cl;
    assign w_dn   = r_mode ? rotr(r_d, w_sr) : w_dl;

    round u_round (
        .subkey   (w_k),
        .in_left  (r_l),
        .in_right (r_r),
        .out_left (w_lo),
        .out_right(w_ro)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // next-state and handshake outputs
    always_comb begin
        w_next    = r_state;
        in_ready  = r_state == IDLE;
        out_valid = r_state == DONE;
        busy      = r_state != IDLE;
        round_idx = r_state == ROUND ? r_cnt : '0;
        case (r_state)
            IDLE:    w_next = in_valid ? ROUND : IDLE;
            ROUND:   w_next = w_last ? DONE : ROUND;
            DONE:    w_next = out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    // load on accept, one round per cycle, latch the undone-swap result on the last round
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_l    <= '0;
            r_r    <= '0;
            r_c    <= '0;
            r_d    <= '0;
            r_mode <= 1'b0;
            r_cnt  <= '0;
            r_out  <= '0;
        end else if (r_state == IDLE && in_valid) begin
            {r_l, r_r} <= ip_f(in_block);
            {r_c, r_d} <= pc1_f(in_key);
            r_mode     <= in_decrypt;
            r_cnt      <= '0;
        end else if (r_state == ROUND) begin
            r_l   <= w_lo;
            r_r   <= w_ro;
            r_c   <= w_cn;
            r_d   <= w_dn;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) r_out <= fp_f({w_ro, w_lo});
        end
    end

    assign out_block = r_out;
endmodule

// File: tb/tb_des_iter_ctrl.sv
// tb_des_iter_ctrl: scoreboard bench for the iterative DES controller against a textbook DES model
module tb_des_iter_ctrl;
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7};
    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int SB [512] = '{
        14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
         0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
         4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
        15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
        15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
         3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
         0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
        13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
        10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
        13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
         1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
         7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
        13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
        10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
         3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
         2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
        14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
         4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
        11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
        12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
        10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
         9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
         4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
         4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
        13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
         1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
         6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
        13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
         1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
         7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
         2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11};

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_block;
    logic [63:0] in_key;
    logic        in_decrypt;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_block;
    logic        busy;
    logic [3:0]  round_idx;

    typedef struct {
        logic [63:0] exp;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   hs_cyc = -100;
    int   rdy_mode = 0;
    int   md;
    bit   mr;
    bit   mdn;

    des_iter_ctrl #(.NUM_ROUNDS(16), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_block  (in_block),
        .in_key    (in_key),
        .in_decrypt(in_decrypt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block),
        .busy      (busy),
        .round_idx (round_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        logic [31:0] s;
        logic [31:0] f;
        logic [5:0]  six;
        int          v;
        for (int j = 0; j < 48; j++) e[47-j] = r[32-E_T[j]];
        e = e ^ k;
        for (int b = 0; b < 8; b++) begin
            six = e[47-6*b -: 6];
            v = SB[b*64 + 32*int'(six[5]) + 16*int'(six[0]) + int'(six[4:1])];
            s[31-4*b -: 4] = v[3:0];
        end
        for (int j = 0; j < 32; j++) f[31-j] = s[32-P_T[j]];
        return f;
    endfunction

    // Textbook DES: full subkey list up front, then 16 Feistel rounds and the inverse of IP
    function automatic logic [63:0] des_ref(input logic [63:0] key, input logic [63:0] blk, input bit dec);
        int          sh [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
        logic [55:0] cd;
        logic [27:0] c;
        logic [27:0] d;
        logic [47:0] ks [16];
        logic [63:0] x;
        logic [63:0] y;
        logic [31:0] l;
        logic [31:0] r;
        logic [31:0] t;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < sh[i]; j++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int j = 0; j < 48; j++) ks[i][47-j] = cd[56-PC2_T[j]];
        end
        for (int i = 0; i < 64; i++) x[63-i] = blk[64-IP_T[i]];
        l = x[63:32];
        r = x[31:0];
        for (int i = 0; i < 16; i++) begin
            t = l ^ feistel(r, dec ? ks[15-i] : ks[i]);
            l = r;
            r = t;
        end
        x = {r, l};
        y = '0;
        for (int i = 0; i < 64; i++) y[64-IP_T[i]] = x[63-i];
        return y;
    endfunction

    // consumer: always ready, random, or stalled
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom % 2) : 1'b0;
        end
    end

    // monitor: derives the expected state from the scoreboard head and pops on handshake
    always @(negedge clk) begin
        if (rst_n) begin
            md  = q.size() > 0 ? cyc - q[0].acc : -1;
            mr  = q.size() > 0 && md >= 0 && md < 16;
            mdn = q.size() > 0 && md >= 16;
            chk("out_valid", 64'(out_valid), 64'(mdn));
            chk("in_ready", 64'(in_ready), 64'(!(mr || mdn)));
            chk("busy", 64'(busy), 64'(mr || mdn));
            chk("round_idx", 64'(round_idx), mr ? 64'(md) : 64'd0);
            if (mdn) begin
                chk("out_block", out_block, q[0].exp);
                if (out_ready) begin
                    hs_cyc = cyc + 1;
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [63:0] k, input logic [63:0] b, input bit dec,
                        input logic [63:0] exp, input bit hold, input bit b2b);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        in_key     = k;
        in_block   = b;
        in_decrypt = dec;
        in_valid   = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) begin
            chk("accept_timeout", 64'(n), 64'd0);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        q.push_back('{exp, cyc});
        if (!hold) in_valid = 1'b0;
        if (b2b) chk("b2b_gap", 64'(cyc), 64'(hs_cyc + 1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(q.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_block"}, out_block, 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_round_idx"}, 64'(round_idx), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] k;
        logic [63:0] b;
        logic [63:0] b2;
        bit          dec;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_block   = '0;
        in_key     = '0;
        in_decrypt = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        send(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405, 1'b0, 1'b0);
        drain();
        send(64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b1, 64'h0123456789ABCDEF, 1'b0, 1'b0);
        drain();
        send(64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b0, 64'h0000000000000000, 1'b0, 1'b0);
        drain();
        send(64'h0E329232EA6D0D73 ^ 64'h0101010101010101, 64'h8787878787878787, 1'b0, 64'h0000000000000000, 1'b0, 1'b0);
        drain();

        rdy_mode = 1;
        for (int i = 0; i < 8; i++) begin
            k   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
            dec = 1'($urandom % 2);
            send(k, b, dec, des_ref(k, b, dec), 1'b0, 1'b0);
        end
        drain();

        rdy_mode = 2;
        k = {$urandom, $urandom};
        b = {$urandom, $urandom};
        send(k, b, 1'b1, des_ref(k, b, 1'b1), 1'b0, 1'b0);
        for (int n = 0; n < 40 && !out_valid; n++) @(negedge clk);
        #1;
        in_valid = 1'b1;
        in_block = {$urandom, $urandom};
        repeat (20) @(negedge clk);
        #1;
        in_valid = 1'b0;
        rdy_mode = 0;
        drain();

        k = 64'h133457799BBCDFF1;
        send(k, 64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        q.delete();
        #1 check_reset_vals("midreset");
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        send(k, 64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405, 1'b0, 1'b0);
        drain();

        k  = {$urandom, $urandom};
        b  = {$urandom, $urandom};
        b2 = {$urandom, $urandom};
        send(k, b, 1'b0, des_ref(k, b, 1'b0), 1'b1, 1'b0);
        send(k, b2, 1'b1, des_ref(k, b2, 1'b1), 1'b0, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
